wb_stage: RTL

Writeback stage of the RISC-V core: accepts completed instructions from the memory stage through a valid/ready handshake and drives the single write port of the integer register file. ALU/CSR results are written one cycle after acceptance. Loads wait for the LSU read response, then are byte/halfword-selected and sign/zero-extended before writing. The block reports the pending load destination to the hazard unit so that load-use stalls can be generated.

---
 rtl/wb_stage.sv | 83 ++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage that sends completed ALU/CSR results and extended load data to the register file write port.
// Ports: i_clk/i_rst (async, active low); i_valid/o_ready handshake with MEM carrying i_rd, i_result,
// i_is_load, i_funct3, i_addr_lo; i_lsu_rvalid/i_lsu_rdata LSU read response; o_wreg/o_wdata/o_we
// register file write; o_retire one pulse per instruction; o_pend_valid/o_pend_rd pending load for hazards.
module wb_stage #(
  parameter int DataWidth = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [4:0]           i_rd,
  input  logic [DataWidth-1:0] i_result,
  input  logic                 i_is_load,
  input  logic [2:0]           i_funct3,
  input  logic [1:0]           i_addr_lo,
  input  logic                 i_lsu_rvalid,
  input  logic [DataWidth-1:0] i_lsu_rdata,
  output logic [4:0]           o_wreg,
  output logic [DataWidth-1:0] o_wdata,
  output logic                 o_we,
  output logic                 o_retire,
  output logic                 o_pend_valid,
  output logic [4:0]           o_pend_rd
);
  typedef enum logic [1:0] {IDLE, ALU_WB, LOAD_WAIT, LOAD_WB} state_t;
  state_t state, state_nx;
  logic [4:0] rd_q;
  logic [2:0] funct3_q;
  logic [1:0] addr_q;
  logic acc, ld_done, wr;
  logic [4:0] wreg_nx;
  logic [DataWidth-1:0] wdata_nx, ld_data;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  assign o_ready = state != LOAD_WAIT;
  always_comb begin
    acc = i_valid && o_ready;
    ld_done = state == LOAD_WAIT && i_lsu_rvalid;
    state_nx = state == LOAD_WAIT ? (i_lsu_rvalid ? LOAD_WB : LOAD_WAIT)
             : acc ? (i_is_load ? LOAD_WAIT : ALU_WB) : IDLE;
    lane_b = i_lsu_rdata[{addr_q, 3'b000} +: 8];
    lane_h = addr_q[1] ? i_lsu_rdata[31:16] : i_lsu_rdata[15:0];
    ld_data = funct3_q == 3'b000 ? {{(DataWidth-8){lane_b[7]}}, lane_b}
            : funct3_q == 3'b100 ? {{(DataWidth-8){1'b0}}, lane_b}
            : funct3_q == 3'b001 ? {{(DataWidth-16){lane_h[15]}}, lane_h}
            : funct3_q == 3'b101 ? {{(DataWidth-16){1'b0}}, lane_h}
            : i_lsu_rdata;
    // a write cycle follows either a load response or an accepted non-load
    wr = ld_done || (acc && !i_is_load);
    wreg_nx = ld_done ? rd_q : i_rd;
    wdata_nx = ld_done ? ld_data : i_result;
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      rd_q <= '0;
      funct3_q <= '0;
      addr_q <= '0;
      o_wreg <= '0;
      o_wdata <= '0;
      o_we <= 1'b0;
      o_retire <= 1'b0;
      o_pend_valid <= 1'b0;
      o_pend_rd <= '0;
    end else begin
      if (acc) begin
        rd_q <= i_rd;
        funct3_q <= i_funct3;
        addr_q <= i_addr_lo;
      end
      if (wr) begin
        o_wreg <= wreg_nx;
        o_wdata <= wdata_nx;
      end
      o_we <= wr && wreg_nx != 5'd0;
      o_retire <= wr;
      o_pend_valid <= state_nx == LOAD_WAIT;
      o_pend_rd <= state_nx == LOAD_WAIT ? (acc ? i_rd : rd_q) : 5'd0;
    end
endmodule
